// File: rtl/mac_tree_pkg.sv
// Shared types, default parameters and width helpers for the MAC tap sequencer.
package mac_tree_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_COEFF_WIDTH = 8;
  localparam int DEF_NUM_TAPS    = 8;
  localparam int DEF_TREE_LAT    = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUTPUT
  } seq_state_t;

  // One tree result: two products plus headroom.
  function automatic int res_width(input int data_w, input int coeff_w);
    return data_w + coeff_w + 2;
  endfunction

  function automatic int acc_width(input int res_w, input int num_taps);
    return res_w + $clog2(num_taps / 2) + 1;
  endfunction

  // Width of the pair index k; kept at least one bit wide for NUM_TAPS == 2.
  function automatic int pair_width(input int num_taps);
    return ((num_taps / 2) > 1) ? $clog2(num_taps / 2) : 1;
  endfunction

endpackage

// File: rtl/tap_coeff_bank.sv
// Sample delay line plus writable coefficient registers, read out as
// (even, odd) tap pairs selected by a pair index.
module tap_coeff_bank
  import mac_tree_pkg::*;
#(
  parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter  int NUM_TAPS    = DEF_NUM_TAPS,
  localparam int AW          = $clog2(NUM_TAPS),
  localparam int PW          = pair_width(NUM_TAPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift_en_i,
  input  logic [DATA_WIDTH-1:0]  shift_data_i,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [COEFF_WIDTH-1:0] wr_data_i,
  input  logic [PW-1:0]          rd_pair_i,
  output logic [DATA_WIDTH-1:0]  rd_data1_o,
  output logic [COEFF_WIDTH-1:0] rd_coeff1_o,
  output logic [DATA_WIDTH-1:0]  rd_data2_o,
  output logic [COEFF_WIDTH-1:0] rd_coeff2_o
);

  logic [DATA_WIDTH-1:0]  taps_q  [NUM_TAPS];
  logic [COEFF_WIDTH-1:0] coeff_q [NUM_TAPS];
  logic                   addr_ok;
  logic [AW-1:0]          idx_even;
  logic [AW-1:0]          idx_odd;

  if (NUM_TAPS == (1 << AW)) begin : g_full_range
    assign addr_ok = 1'b1;
  end else begin : g_part_range
    assign addr_ok = (wr_addr_i < AW'(NUM_TAPS));
  end

  always_ff @(posedge clk) begin
    // NOTE: the coefficient bank is reset as well, so a reset leaves the filter with an all-zero response.
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        taps_q[i]  <= '0;
        coeff_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every tap take its neighbour's pre-edge value.
      if (shift_en_i) begin
        taps_q[0] <= shift_data_i;
        for (int i = 1; i < NUM_TAPS; i++) begin
          taps_q[i] <= taps_q[i-1];
        end
      end
      if (wr_en_i && addr_ok) begin
        coeff_q[wr_addr_i] <= wr_data_i;
      end
    end
  end

  assign idx_even    = AW'({rd_pair_i, 1'b0});
  assign idx_odd     = idx_even + AW'(1);
  assign rd_data1_o  = taps_q[idx_even];
  assign rd_coeff1_o = coeff_q[idx_even];
  assign rd_data2_o  = taps_q[idx_odd];
  assign rd_coeff2_o = coeff_q[idx_odd];

endmodule

// File: rtl/mac_tap_sequencer.sv
// Streaming sequencer for the two-level MAC tree: accepts a sample, issues
// NUM_TAPS/2 operand pairs, sums the delayed tree results and emits one output.
module mac_tap_sequencer
  import mac_tree_pkg::*;
#(
  parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter  int NUM_TAPS    = DEF_NUM_TAPS,
  parameter  int TREE_LAT    = DEF_TREE_LAT,
  localparam int RES_WIDTH   = res_width(DATA_WIDTH, COEFF_WIDTH),
  localparam int ACC_WIDTH   = acc_width(RES_WIDTH, NUM_TAPS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        coeff_wr_en,
  input  logic [$clog2(NUM_TAPS)-1:0] coeff_wr_addr,
  input  logic [COEFF_WIDTH-1:0]      coeff_wr_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic [DATA_WIDTH-1:0]       tree_data1,
  output logic [DATA_WIDTH-1:0]       tree_data2,
  output logic [COEFF_WIDTH-1:0]      tree_coeff1,
  output logic [COEFF_WIDTH-1:0]      tree_coeff2,
  input  logic [RES_WIDTH-1:0]        tree_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_WIDTH-1:0]        out_data
);

  localparam int P  = NUM_TAPS / 2;
  localparam int PW = pair_width(NUM_TAPS);
  // Issue-valid line pattern on the cycle the final result retires.
  localparam logic [TREE_LAT-1:0] LAST_VLD = TREE_LAT'(1) << (TREE_LAT - 1);

  seq_state_t            state_q, state_d;
  logic [PW-1:0]         k_q, k_d;
  logic [TREE_LAT-1:0]   vld_q, vld_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  accept;
  logic                  push;
  logic [DATA_WIDTH-1:0]  rd_data1, rd_data2;
  logic [COEFF_WIDTH-1:0] rd_coeff1, rd_coeff2;

  tap_coeff_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH),
    .NUM_TAPS    (NUM_TAPS)
  ) u_bank (
    .clk          (clk),
    .reset        (reset),
    .shift_en_i   (accept),
    .shift_data_i (in_data),
    .wr_en_i      (coeff_wr_en && (state_q == IDLE)),
    .wr_addr_i    (coeff_wr_addr),
    .wr_data_i    (coeff_wr_data),
    .rd_pair_i    (k_q),
    .rd_data1_o   (rd_data1),
    .rd_coeff1_o  (rd_coeff1),
    .rd_data2_o   (rd_data2),
    .rd_coeff2_o  (rd_coeff2)
  );

  always_comb begin
    // NOTE: every next-state value and output gets a default first, so no path leaves one unassigned (no latch).
    state_d     = state_q;
    k_d         = k_q;
    accept      = 1'b0;
    push        = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    tree_data1  = '0;
    tree_coeff1 = '0;
    tree_data2  = '0;
    tree_coeff2 = '0;

    case (state_q)
      IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset) begin
          accept  = 1'b1;
          k_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        push        = 1'b1;
        tree_data1  = rd_data1;
        tree_coeff1 = rd_coeff1;
        tree_data2  = rd_data2;
        tree_coeff2 = rd_coeff2;
        if (k_q == PW'(P - 1)) begin
          state_d = DRAIN;
        end else begin
          k_d = k_q + PW'(1);
        end
      end
      DRAIN: begin
        if (vld_q == LAST_VLD) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        out_data  = acc_q;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    vld_d = (vld_q << 1) | TREE_LAT'(push);

    // The valid line is empty in IDLE, so clearing on accept never drops a result.
    acc_d = acc_q;
    if (accept) begin
      acc_d = '0;
    end else if (vld_q[TREE_LAT-1]) begin
      acc_d = acc_q + ACC_WIDTH'(tree_result);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      vld_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      vld_q   <= vld_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// Directed plus randomized bench for mac_tap_sequencer, with a tap-history
// reference model and a delayed-product model of the MAC tree.
module tb_mac_tap_sequencer;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int NT = 4;
  localparam int TL = 2;
  localparam int P  = NT / 2;
  localparam int RW = DW + CW + 2;
  localparam int AW = RW + $clog2(P) + 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  coeff_wr_en;
  logic [$clog2(NT)-1:0] coeff_wr_addr;
  logic [CW-1:0]         coeff_wr_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_data;
  logic [DW-1:0]         tree_data1, tree_data2;
  logic [CW-1:0]         tree_coeff1, tree_coeff2;
  logic [RW-1:0]         tree_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [AW-1:0]         out_data;

  int total = 0;
  int bad   = 0;

  // Reference model: newest sample first, coefficient per tap index.
  longint unsigned hist  [NT];
  longint unsigned cmodel[NT];

  mac_tap_sequencer #(
    .DATA_WIDTH  (DW),
    .COEFF_WIDTH (CW),
    .NUM_TAPS    (NT),
    .TREE_LAT    (TL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .coeff_wr_en   (coeff_wr_en),
    .coeff_wr_addr (coeff_wr_addr),
    .coeff_wr_data (coeff_wr_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .tree_data1    (tree_data1),
    .tree_data2    (tree_data2),
    .tree_coeff1   (tree_coeff1),
    .tree_coeff2   (tree_coeff2),
    .tree_result   (tree_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
  );

  always #5 clk = ~clk;

  // Tree model: d1*c1+d2*c2 delayed TL cycles. Outside the P issue cycles that
  // follow each observed accept it returns nonzero junk, so stray accumulation shows up.
  logic [RW-1:0] pipe [TL];
  int unsigned cyc    = 0;
  int unsigned win_lo = 1;
  int unsigned win_hi = 0;
  int unsigned prod;
  bit          in_win;

  always @(posedge clk) begin
    in_win = (cyc >= win_lo) && (cyc <= win_hi);
    prod = 32'(tree_data1) * 32'(tree_coeff1) + 32'(tree_data2) * 32'(tree_coeff2);
    pipe[0] <= in_win ? RW'(prod) : RW'($urandom_range(1, 4095));
    for (int i = 1; i < TL; i++) pipe[i] <= pipe[i-1];
    if (reset) begin
      win_lo = 1;
      win_hi = 0;
    end else if (in_valid && in_ready) begin
      win_lo = cyc + 1;
      win_hi = cyc + P;
    end
    cyc++;
  end

  assign tree_result = pipe[TL-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned model_out();
    longint unsigned s = 0;
    for (int i = 0; i < NT; i++) s += hist[i] * cmodel[i];
    return s;
  endfunction

  task automatic model_push(input longint unsigned d);
    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NT; i++) begin
      hist[i]   = 0;
      cmodel[i] = 0;
    end
  endtask

  task automatic write_coeff(input int addr, input int data, input bit taken);
    coeff_wr_en   = 1'b1;
    coeff_wr_addr = addr[$clog2(NT)-1:0];
    coeff_wr_data = data[CW-1:0];
    tick();
    coeff_wr_en = 1'b0;
    if (taken) cmodel[addr] = longint'(data);
  endtask

  task automatic send(input int d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d[DW-1:0];
    while (!in_ready && n < 32) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    model_push(longint'(d));
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_data"}, out_data, model_out());
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    int stall;
    int a, c, d;
    reset         = 1'b1;
    coeff_wr_en   = 1'b0;
    coeff_wr_addr = '0;
    coeff_wr_data = '0;
    in_valid      = 1'b0;
    in_data       = '0;
    out_ready     = 1'b1;
    model_clear();

    // Reset values.
    tick();
    tick();
    check("rst_cycle_in_ready", in_ready, 0);
    reset = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_tree_data1", tree_data1, 0);
    check("rst_tree_coeff2", tree_coeff2, 0);

    // 1/2: coefficients {1,2,3,4}, samples 10, 20, 30.
    for (int i = 0; i < NT; i++) write_coeff(i, i + 1, 1'b1);
    send(10);
    wait_result("s10", P + TL);
    check("s10_const", out_data, 10);
    handshake("s10");
    send(20);
    wait_result("s20", P + TL);
    check("s20_const", out_data, 40);
    handshake("s20");
    send(30);
    wait_result("s30", P + TL);
    check("s30_const", out_data, 100);
    handshake("s30");

    // 3: backpressure, with the next sample held on in_valid throughout.
    out_ready = 1'b0;
    send(40);
    wait_result("bp40", P + TL);
    in_valid = 1'b1;
    in_data  = 8'd50;
    for (int i = 0; i < 7; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 200);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    handshake("bp40");
    check("bp_ready_after_hs", in_ready, 1);
    send(50);
    wait_result("s50", P + TL);
    handshake("s50");

    // 4: coefficient write during ISSUE is dropped; same-cycle IDLE write is used.
    send(7);
    write_coeff(0, 9, 1'b0);
    wait_result("s7", P + TL - 1);
    handshake("s7");
    send(2);
    wait_result("s2_drop", P + TL);
    handshake("s2");
    coeff_wr_en   = 1'b1;
    coeff_wr_addr = '0;
    coeff_wr_data = 8'd9;
    in_valid      = 1'b1;
    in_data       = 8'd3;
    check("wr_accept_ready", in_ready, 1);
    tick();
    coeff_wr_en = 1'b0;
    in_valid    = 1'b0;
    cmodel[0]   = 9;
    model_push(3);
    wait_result("s3_newcoeff", P + TL);
    handshake("s3");

    // 5: reset while draining.
    send(11);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_tree_data1", tree_data1, 0);
    check("midrst_tree_data2", tree_data2, 0);
    check("midrst_tree_coeff1", tree_coeff1, 0);
    check("midrst_in_ready", in_ready, 0);
    reset = 1'b0;
    model_clear();
    tick();
    check("postrst_in_ready", in_ready, 1);
    repeat (4) tick();
    check("postrst_no_output", out_valid, 0);
    send(5);
    wait_result("s5_zero", P + TL);
    check("s5_const", out_data, 0);
    handshake("s5");

    // Randomized coefficients, samples and backpressure.
    for (int it = 0; it < 8; it++) begin
      a = int'($urandom_range(0, NT - 1));
      c = int'($urandom_range(0, 255));
      d = int'($urandom_range(0, 255));
      stall = int'($urandom_range(0, 3));
      write_coeff(a, c, 1'b1);
      out_ready = (stall == 0);
      send(d);
      wait_result("rnd", P + TL);
      for (int s = 0; s < stall; s++) begin
        tick();
        check("rnd_stall_data", out_data, model_out());
      end
      handshake("rnd");
    end

    // 6: all-ones samples and coefficients, no overflow.
    for (int i = 0; i < NT; i++) write_coeff(i, 255, 1'b1);
    for (int i = 0; i < NT; i++) begin
      send(255);
      wait_result("ones", P + TL);
      if (i == NT - 1) check("ones_full", out_data, NT * 255 * 255);
      handshake("ones");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
